// File: rtl/dram_port_arbiter_pkg.sv
// Shared encodings and defaults for the two-port DRAM user-port arbiter.
package dram_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_DONE  = 3'd3,
    ST_RESP       = 3'd4
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int START_TIMEOUT_DEF = 64;

endpackage

// File: rtl/dram_port_arbiter_rr_arb2.sv
// Two-input grant selection: round-robin against last_owner, or port 0 first.
module rr_arb2
  import dram_port_arbiter_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  always_comb begin
    gnt_vld = |req;
    gnt_idx = PORT_CPU;
    if (req == 2'b11)
      gnt_idx = (FIXED_PRIORITY != 0) ? PORT_CPU : ~last_owner;
    else if (req[1])
      gnt_idx = PORT_DMA;
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares the single-command DRAM user port between the CPU and DMA requesters,
// one outstanding command at a time, with a sticky start-timeout flag.
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int WDATA_WIDTH    = 32,
  parameter int RDATA_WIDTH    = 128,
  parameter int MASK_WIDTH     = 4,
  parameter int FIXED_PRIORITY = 0,
  parameter int START_TIMEOUT  = START_TIMEOUT_DEF
) (
  input  logic                   core_clk,
  input  logic                   core_rst_x,
  input  logic                   m0_req,
  input  logic                   m0_we,
  input  logic [ADDR_WIDTH-1:0]  m0_addr,
  input  logic [WDATA_WIDTH-1:0] m0_wdata,
  input  logic [MASK_WIDTH-1:0]  m0_mask,
  output logic                   m0_ack,
  output logic [RDATA_WIDTH-1:0] m0_rdata,
  input  logic                   m1_req,
  input  logic                   m1_we,
  input  logic [ADDR_WIDTH-1:0]  m1_addr,
  input  logic [WDATA_WIDTH-1:0] m1_wdata,
  input  logic [MASK_WIDTH-1:0]  m1_mask,
  output logic                   m1_ack,
  output logic [RDATA_WIDTH-1:0] m1_rdata,
  input  logic                   dram_calib,
  input  logic                   dram_busy,
  input  logic [RDATA_WIDTH-1:0] dram_rdata,
  output logic                   dram_rd_en,
  output logic                   dram_wr_en,
  output logic [ADDR_WIDTH-1:0]  dram_addr,
  output logic [WDATA_WIDTH-1:0] dram_wdata,
  output logic [MASK_WIDTH-1:0]  dram_mask,
  output logic                   o_err
);

  localparam int CNT_W = $clog2(START_TIMEOUT) + 1;

  arb_state_e             state, state_nxt;
  logic                   owner, we_r, last_owner, err_r;
  logic [ADDR_WIDTH-1:0]  addr_r;
  logic [WDATA_WIDTH-1:0] wdata_r;
  logic [MASK_WIDTH-1:0]  mask_r;
  logic [RDATA_WIDTH-1:0] rdata_r;
  logic [CNT_W-1:0]       cnt;
  logic                   gnt_vld, gnt_idx, start_ok, timeout_hit;

  rr_arb2 #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_arb (
    .req        ({m1_req, m0_req}),
    .last_owner (last_owner),
    .gnt_vld    (gnt_vld),
    .gnt_idx    (gnt_idx)
  );

  assign start_ok    = gnt_vld & dram_calib & ~dram_busy;
  assign timeout_hit = (cnt == CNT_W'(START_TIMEOUT - 1));

  always_ff @(posedge core_clk or negedge core_rst_x) begin
    if (!core_rst_x) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Command strobes and acks are decoded from state so reset kills them at once.
  always_comb begin
    state_nxt  = state;
    dram_rd_en = 1'b0;
    dram_wr_en = 1'b0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    case (state)
      ST_IDLE:       if (start_ok) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        dram_rd_en = ~we_r;
        dram_wr_en = we_r;
        state_nxt  = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (dram_busy)        state_nxt = ST_WAIT_DONE;
        else if (timeout_hit) state_nxt = ST_RESP;
      end
      ST_WAIT_DONE:  if (!dram_busy) state_nxt = ST_RESP;
      ST_RESP: begin
        m0_ack    = (owner == PORT_CPU);
        m1_ack    = (owner == PORT_DMA);
        state_nxt = ST_IDLE;
      end
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rst_x) begin
    if (!core_rst_x) begin
      owner      <= PORT_CPU;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      mask_r     <= '0;
      rdata_r    <= '0;
      cnt        <= '0;
      err_r      <= 1'b0;
      last_owner <= PORT_DMA;
    end else begin
      case (state)
        ST_IDLE: if (start_ok) begin
          owner <= gnt_idx;
          if (gnt_idx == PORT_DMA) begin
            we_r    <= m1_we;
            addr_r  <= m1_addr;
            wdata_r <= m1_wdata;
            mask_r  <= m1_mask;
          end else begin
            we_r    <= m0_we;
            addr_r  <= m0_addr;
            wdata_r <= m0_wdata;
            mask_r  <= m0_mask;
          end
        end
        ST_ISSUE: cnt <= '0;
        ST_WAIT_START: if (!dram_busy) begin
          if (timeout_hit) begin
            err_r   <= 1'b1;
            rdata_r <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: if (!dram_busy && !we_r) rdata_r <= dram_rdata;
        ST_RESP: last_owner <= owner;
        default: ;
      endcase
    end
  end

  assign dram_addr  = addr_r;
  assign dram_wdata = wdata_r;
  assign dram_mask  = mask_r;
  assign m0_rdata   = rdata_r;
  assign m1_rdata   = rdata_r;
  assign o_err      = err_r;

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single-command DRAM user port (rd_en/wr_en/addr/data/mask in; 128-bit read line and busy out) between two requesters in the core clock domain. Port 0 is the CPU memory stage; port 1 is the boot loader / DMA path.
- Sequences each command through the port's busy handshake and returns read data and a completion strobe to the owning requester.
- Enforces one outstanding command at a time, with round-robin or fixed-priority selection.

Parameters:
- ADDR_WIDTH, 32, requester and DRAM command address width.
- WDATA_WIDTH, 32, write data width.
- RDATA_WIDTH, 128, read line width returned by the DRAM port.
- MASK_WIDTH, 4, byte mask width. Passed through unchanged; 1 = byte not written, same polarity as the DRAM port.
- FIXED_PRIORITY, 0, selection mode. 0 = round-robin; 1 = port 0 always wins.
- START_TIMEOUT, 64, cycles allowed between command issue and busy assertion before an error is flagged.

Ports:
- core_clk  in  1  Clock.
- core_rst_x  in  1  Reset, asynchronous, active-low.
- m0_req  in  1  Port 0 request. Held with its fields until m0_ack.
- m0_we  in  1  Port 0 operation: 1 = write, 0 = read.
- m0_addr  in  ADDR_WIDTH  Port 0 address.
- m0_wdata  in  WDATA_WIDTH  Port 0 write data.
- m0_mask  in  MASK_WIDTH  Port 0 byte mask.
- m0_ack  out  1  One-cycle completion strobe for port 0.
- m0_rdata  out  RDATA_WIDTH  Port 0 read line. Valid while m0_ack is high for a read.
- m1_req, m1_we, m1_addr, m1_wdata, m1_mask, m1_ack, m1_rdata: identical to port 0, for port 1.
- dram_calib  in  1  Calibration complete, already synchronised to core_clk.
- dram_busy  in  1  DRAM port busy.
- dram_rdata  in  RDATA_WIDTH  DRAM read line.
- dram_rd_en  out  1  Read command pulse.
- dram_wr_en  out  1  Write command pulse.
- dram_addr  out  ADDR_WIDTH  Command address.
- dram_wdata  out  WDATA_WIDTH  Command write data.
- dram_mask  out  MASK_WIDTH  Command byte mask.
- o_err  out  1  Sticky start-timeout flag.

Behaviour:
- Reset values:
  - State is IDLE.
  - All enables, acks and o_err are 0.
  - All address, data and mask registers are 0.
  - last_owner = 1, so port 0 wins the first contention.
  - Timeout counter = 0.
- States:
  - IDLE: arbitrate when (m0_req | m1_req) & dram_calib & !dram_busy. Latch owner, we, addr, wdata and mask into registers, then go to ISSUE.
  - ISSUE: drive dram_rd_en = !we or dram_wr_en = we for exactly this one cycle. Clear the counter. Go to WAIT_START.
  - WAIT_START: if dram_busy, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches START_TIMEOUT-1: set o_err, load rdata_reg = 0, go to RESP.
  - WAIT_DONE: when !dram_busy, capture dram_rdata into rdata_reg (reads only; writes leave it unchanged), then go to RESP.
  - RESP: assert the owner's ack for one cycle. Set last_owner = owner. Go to IDLE.
- Arbitration:
  - Round-robin: if both ports request, grant the port != last_owner.
  - FIXED_PRIORITY=1: port 0 wins whenever it requests.
  - A single requester is granted immediately.
- Outputs:
  - dram_addr, dram_wdata and dram_mask come from the latched registers and stay stable from ISSUE through RESP.
  - mX_rdata = rdata_reg for both ports; only the acked port may consume it.
  - The ack for the non-owner is 0.
- Latency: grant edge to ack is 3 cycles + busy duration. Minimum is 4 cycles when busy is high for one cycle.
- Handshake:
  - The requester drops req, or presents a new request, on the edge after seeing ack.
  - Requests are never accepted in ISSUE, WAIT_* or RESP.
  - A request arriving during another port's transaction waits; it is not lost.
- Boundary conditions:
  - dram_calib low or dram_busy high in IDLE: no grant, requests wait.
  - Both ports request in the same cycle while busy: arbitration happens on the first eligible cycle.
  - Timeout path: ack is still returned, rdata = 0, o_err stays 1 until reset.
- Reset mid-operation:
  - Enables and acks drop asynchronously; state returns to IDLE.
  - The in-flight DRAM command is abandoned; the DRAM port is reset by the same reset.

Decomposition:
- Shared package contains:
  - State encodings ST_IDLE..ST_RESP, 3 bits.
  - Port index constants PORT_CPU = 0, PORT_DMA = 1.
  - Default START_TIMEOUT.
- One sub-module, rr_arb2: a 2-input round-robin/fixed-priority grant function using the last_owner register. Everything else stays in the top-level FSM.

Test Plan:
- Port 0 read, addr 0x0000_1000. Busy high 5 cycles, dram_rdata = 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 -> exactly one dram_rd_en pulse with dram_addr = 0x1000; m0_ack for one cycle with m0_rdata equal to that line; m1_ack stays 0.
- Port 1 write, addr 0x40, wdata 0xDEADBEEF, mask 0x3 -> one dram_wr_en pulse with those values held through RESP; m1_ack once.
- Both ports request in the same cycle, three times back-to-back, FIXED_PRIORITY=0 -> grant order 0, 1, 0. With FIXED_PRIORITY=1 -> 0, 0, 0 while port 0 keeps requesting.
- Request with dram_calib = 0 for 20 cycles, then calib rises -> no enable before calib; issue occurs within 1 cycle after calib rises.
- Busy never asserts after issue, START_TIMEOUT = 64 -> o_err = 1 after 64 WAIT_START cycles; owner acked with rdata = 0; next request still serviced.
- core_rst_x asserted while in WAIT_DONE -> enables and acks go to 0 immediately; after release the first request of the contention goes to port 0.
